seq_divider: RTL
================

# seq_divider

Iterative restoring divider that sits directly downstream of the pipelined multi-operand adder. It consumes the adder's sum as the dividend, with a divisor supplied alongside (typically the operand count), and produces quotient and remainder. Typical use is averaging and normalization. It uses the same valid/ready handshake as the adder, produces one quotient bit per clock, and holds one operation in flight.

## Interface
- DIVIDEND_WIDTH, default 14: dividend and quotient width; matches the upstream sum width.
- DIVISOR_WIDTH, default 4: divisor and remainder width.
- SIGNED, default 0: 0 means unsigned operands; 1 means two's-complement operands and results.
- clk_i  input  1  single clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- dividend_i  input  DIVIDEND_WIDTH  dividend (upstream sum).
- divisor_i  input  DIVISOR_WIDTH  divisor.
- data_valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands this cycle.
- quotient_o  output  DIVIDEND_WIDTH  quotient, registered.
- remainder_o  output  DIVISOR_WIDTH  remainder, registered.
- div_by_zero_o  output  1  result came from a zero divisor; qualified by data_valid_o.
- data_valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.

## Operation
- FSM states: IDLE, CALC, FIX (present only when SIGNED=1), ROUND (present only with the macro), DONE.
- Accept: data_valid_i && ready_o on a rising edge latches the operands.
  - SIGNED=1 latches the operand magnitudes and the result signs.
  - Divisor != 0: go to CALC, bit counter = DIVIDEND_WIDTH-1, partial remainder = 0.
  - Divisor == 0: go directly to DONE.
- CALC, one step per cycle:
  - Partial remainder = {partial remainder, next dividend MSB}.
  - Subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Partial remainder register is DIVISOR_WIDTH+1 bits.
  - When the counter reaches 0, go to FIX if SIGNED=1, else ROUND if enabled, else DONE.
- FIX: negate the quotient if the operand signs differ. Negate the remainder if the dividend was negative (truncation toward zero). Then go to ROUND if enabled, else DONE.
- Signed overflow: most-negative dividend / -1 wraps, so quotient_o = most-negative value and remainder_o = 0. No flag is raised.
- Divide by zero: quotient_o = all ones (both modes), remainder_o = 0, div_by_zero_o = 1.
- DONE: data_valid_o = 1. Outputs stay stable until data_valid_o && ready_i.
  - On that handshake, go to IDLE, or accept new operands directly if data_valid_i is high.
- ready_o = (state == IDLE) || (state == DONE && ready_i). This is a combinational path from ready_i, as in the upstream adder.

## Timing
- Reset (rst_n_i low, any state, including mid-CALC): state = IDLE; quotient_o = 0, remainder_o = 0, div_by_zero_o = 0, data_valid_o = 0.
  - Any operation in flight is discarded.
  - ready_o = 1 while rst_n_i is low and after release.
- Latency, from the accept edge to the edge after which data_valid_o is high:
  - Base: DIVIDEND_WIDTH cycles.
  - +1 if SIGNED=1.
  - +1 with the macro.
  - Divide by zero: 1 cycle.
- Throughput: one operation per (latency + 1) cycles when ready_i is held high. The DONE-to-CALC transition allows back-to-back operation with no IDLE cycle.
- Operands on dividend_i/divisor_i are sampled only at the accept edge. They may change freely afterwards.
- ready_o is low throughout CALC, FIX and ROUND.

## Configuration
- DIVIDER_ROUND_EN defined:
  - Adds the ROUND state (+1 cycle).
  - If 2·|remainder| >= |divisor|, the quotient magnitude is incremented (round half away from zero).
  - Unsigned all-ones saturates instead of wrapping.
  - remainder_o still reports the unrounded remainder.
  - Divide by zero bypasses ROUND.
- DIVIDER_ROUND_EN undefined: no ROUND state; quotient is truncated toward zero.

## Test plan
- Unsigned, defaults: 100 / 7 -> quotient 14, remainder 2, div_by_zero_o 0. data_valid_o rises 14 cycles after accept.
- Divide by zero: 55 / 0 -> quotient 0x3FFF, remainder 0, div_by_zero_o 1, valid 1 cycle after accept.
- Backpressure:
  - Hold ready_i low 5 cycles in DONE -> outputs stable and ready_o 0 throughout.
  - Raise ready_i with data_valid_i high (30 / 3) -> accepted on the same edge; quotient 10, remainder 0 after 14 more cycles.
- SIGNED=1:
  - -100 / 7 -> quotient 0x3FF2 (-14), remainder 0xE (-2), latency 15.
  - -8192 / -1 -> quotient 0x2000, remainder 0.
- Reset mid-operation: pulse rst_n_i low during cycle 5 of CALC -> all outputs 0, ready_o 1; the next 20 / 4 completes with quotient 5, remainder 0.
- DIVIDER_ROUND_EN:
  - 103 / 7 -> quotient 15, remainder 5, latency 15.
  - 100 / 7 -> quotient 14.
  - 16383 / 1 -> quotient 16383 (saturated).

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, one operation in flight.
// Define DIVIDER_ROUND_EN to add a round-half-away-from-zero stage after the quotient is formed.
module seq_divider #(
    parameter int unsigned DIVIDEND_WIDTH = 14,
    parameter int unsigned DIVISOR_WIDTH  = 4,
    parameter bit          SIGNED         = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    input  logic                      data_valid_i,
    output logic                      ready_o,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o,
    output logic [DIVISOR_WIDTH-1:0]  remainder_o,
    output logic                      div_by_zero_o,
    output logic                      data_valid_o,
    input  logic                      ready_i
);

    localparam int unsigned DW   = DIVIDEND_WIDTH;
    localparam int unsigned VW   = DIVISOR_WIDTH;
    localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;

`ifdef DIVIDER_ROUND_EN
    typedef enum logic [2:0] {StIdle, StCalc, StFix, StRound, StDone} state_e;
    localparam state_e StPost = StRound;
`else
    typedef enum logic [2:0] {StIdle, StCalc, StFix, StDone} state_e;
    localparam state_e StPost = StDone;
`endif

    state_e          state_q, state_d;
    logic [DW-1:0]   dvd_q, dvd_d;      // dividend magnitude, becomes the quotient as it shifts
    logic [VW-1:0]   dsr_q, dsr_d;
    logic [VW:0]     rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dbz_q, dbz_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;

    logic            accept;
    logic            dvd_sign, dsr_sign;
    logic [DW-1:0]   dvd_mag;
    logic [VW-1:0]   dsr_mag;
    logic [VW+1:0]   trial;
    logic            q_bit;

    assign ready_o  = (state_q == StIdle) || ((state_q == StDone) && ready_i);
    assign accept   = data_valid_i && ready_o;

    assign dvd_sign = SIGNED && dividend_i[DW-1];
    assign dsr_sign = SIGNED && divisor_i[VW-1];
    assign dvd_mag  = dvd_sign ? -dividend_i : dividend_i;
    assign dsr_mag  = dsr_sign ? -divisor_i : divisor_i;

    // rem_q[VW] is always zero between steps, so trial[VW+1] is the borrow.
    assign trial    = {rem_q, dvd_q[DW-1]} - {2'b00, dsr_q};
    assign q_bit    = ~trial[VW+1];

`ifdef DIVIDER_ROUND_EN
    logic [VW-1:0] rem_mag;
    logic          round_up;
    logic          saturate;
    assign rem_mag  = rem_neg_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
    assign round_up = {rem_mag, 1'b0} >= {1'b0, dsr_q};
    assign saturate = !SIGNED && (&dvd_q);
`endif

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone && ready_i) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    dsr_d     = dsr_mag;
                    quo_neg_d = dvd_sign ^ dsr_sign;
                    rem_neg_d = dvd_sign;
                    rem_d     = '0;
                    dbz_d     = (divisor_i == '0);
                    if (divisor_i == '0) begin
                        dvd_d   = '1;
                        state_d = StDone;
                    end else begin
                        dvd_d   = dvd_mag;
                        cnt_d   = CntW'(DW - 1);
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                dvd_d = {dvd_q[DW-2:0], q_bit};
                rem_d = q_bit ? trial[VW:0] : {rem_q[VW-1:0], dvd_q[DW-1]};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = SIGNED ? StFix : StPost;
                end
            end
            StFix: begin
                if (quo_neg_q) begin
                    dvd_d = -dvd_q;
                end
                if (rem_neg_q) begin
                    rem_d = {1'b0, -rem_q[VW-1:0]};
                end
                state_d = StPost;
            end
`ifdef DIVIDER_ROUND_EN
            StRound: begin
                // Quotient is already signed here, so a larger magnitude means moving away from 0.
                if (round_up && !saturate) begin
                    dvd_d = quo_neg_q ? dvd_q - DW'(1) : dvd_q + DW'(1);
                end
                state_d = StDone;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign quotient_o    = dvd_q;
    assign remainder_o   = rem_q[VW-1:0];
    assign div_by_zero_o = dbz_q;
    assign data_valid_o  = (state_q == StDone);

endmodule
